// File: rtl/fir_tx_pkg.sv
// Shared types and defaults for the FIR stream transmitter.
// Holds the state encoding and the pointer-width helper used by the FIFO.
package fir_tx_pkg;

   localparam int unsigned DW_DEF    = 11;
   localparam int unsigned DEPTH_DEF = 16;
   localparam int unsigned GW_DEF    = 4;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT
   } tx_state_t;

   // Address bits needed to index a FIFO of the given depth (minimum 1).
   function automatic int unsigned ptr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   localparam int unsigned PTR_W_DEF = ptr_w(DEPTH_DEF);

endpackage

// File: rtl/fir_stream_tx_if.sv
// Write port, control and FIR-side stream signals of fir_stream_tx.
// The slave modport is the transmitter; the master modport is whoever drives it.
interface fir_stream_tx_if
   import fir_tx_pkg::*;
#(
   parameter int unsigned DW = DW_DEF,
   parameter int unsigned GW = GW_DEF
) ();

   logic          WR_EN;
   logic [DW-1:0] WR_DATA;
   logic          START;
   logic          STOP;
   logic [GW-1:0] GAP;
   logic [DW-1:0] DOUT;
   logic          VOUT;
   logic          FULL;
   logic          EMPTY;
   logic          BUSY;
   logic          DONE;
   logic          OVF;

   modport slave (
      input  WR_EN, WR_DATA, START, STOP, GAP,
      output DOUT, VOUT, FULL, EMPTY, BUSY, DONE, OVF
   );

   modport master (
      output WR_EN, WR_DATA, START, STOP, GAP,
      input  DOUT, VOUT, FULL, EMPTY, BUSY, DONE, OVF
   );

endinterface

// File: rtl/fir_tx_fifo.sv
// Synchronous single-clock FIFO with registered FULL/EMPTY, count and sticky overflow.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module fir_tx_fifo
   import fir_tx_pkg::*;
#(
   parameter  int unsigned DW    = DW_DEF,
   parameter  int unsigned DEPTH = DEPTH_DEF,
   localparam int unsigned AW    = ptr_w(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   output logic [DW-1:0] rd_data,
   output logic          full,
   output logic          empty,
   output logic          ovf,
   output logic [AW:0]   count
);

   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   cnt_nxt;
   logic          push;
   logic          pop;

   assign pop     = rd_en && !empty;
   assign push    = wr_en && (!full || pop);
   assign rd_data = mem[rd_ptr];

   always_comb begin
      cnt_nxt = count;
      if (push && !pop) begin
         cnt_nxt = count + 1'b1;
      end else if (!push && pop) begin
         cnt_nxt = count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Flags are registered from the next count so they are valid right after the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
         ovf    <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= cnt_nxt;
         full  <= (cnt_nxt == FULL_CNT);
         empty <= (cnt_nxt == '0);
         if (wr_en && full && !pop) begin
            ovf <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/fir_stream_tx.sv
// Sample transmitter feeding a FIR DIN/VIN input from a preloaded FIFO.
// Emits one sample per VOUT pulse with a programmable idle gap, then pulses DONE.
module fir_stream_tx
   import fir_tx_pkg::*;
#(
   parameter int unsigned DW    = DW_DEF,
   parameter int unsigned DEPTH = DEPTH_DEF,
   parameter int unsigned GW    = GW_DEF
) (
   input logic                CLK,
   input logic                RST,
   fir_stream_tx_if.slave     tx
);

   localparam int unsigned AW = ptr_w(DEPTH);

   tx_state_t     state;
   tx_state_t     state_nxt;
   logic [GW-1:0] gap_len;
   logic [GW-1:0] gap_len_nxt;
   logic [GW-1:0] gap_cnt;
   logic [GW-1:0] gap_cnt_nxt;
   logic [DW-1:0] dout_q;
   logic [DW-1:0] dout_nxt;
   logic          vout_q;
   logic          vout_nxt;
   logic          done_q;
   logic          done_nxt;
   logic          busy_q;
   logic          pop;

   logic [DW-1:0] head;
   logic          fifo_full;
   logic          fifo_empty;
   logic          fifo_ovf;
   logic [AW:0]   fifo_count;

   fir_tx_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (CLK),
      .rst     (RST),
      .wr_en   (tx.WR_EN),
      .wr_data (tx.WR_DATA),
      .rd_en   (pop),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .ovf     (fifo_ovf),
      .count   (fifo_count)
   );

   always_comb begin
      state_nxt   = state;
      gap_len_nxt = gap_len;
      gap_cnt_nxt = gap_cnt;
      dout_nxt    = dout_q;
      vout_nxt    = 1'b0;
      done_nxt    = 1'b0;
      pop         = 1'b0;
      case (state)
         IDLE: begin
            if (tx.START && !fifo_empty) begin
               gap_len_nxt = tx.GAP;
               state_nxt   = SEND;
            end
         end
         SEND: begin
            // STOP wins over popping, emitting and completing.
            if (tx.STOP) begin
               state_nxt = IDLE;
            end else if (!fifo_empty) begin
               pop      = 1'b1;
               dout_nxt = head;
               vout_nxt = 1'b1;
               if (gap_len != '0) begin
                  gap_cnt_nxt = gap_len;
                  state_nxt   = WAIT;
               end
            end else begin
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end
         end
         WAIT: begin
            if (tx.STOP) begin
               state_nxt = IDLE;
            end else begin
               gap_cnt_nxt = gap_cnt - 1'b1;
               if (gap_cnt == GW'(1)) begin
                  state_nxt = SEND;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         gap_len <= '0;
         gap_cnt <= '0;
         dout_q  <= '0;
         vout_q  <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         gap_len <= gap_len_nxt;
         gap_cnt <= gap_cnt_nxt;
         dout_q  <= dout_nxt;
         vout_q  <= vout_nxt;
         done_q  <= done_nxt;
         busy_q  <= (state_nxt != IDLE);
      end
   end

   assign tx.DOUT  = dout_q;
   assign tx.VOUT  = vout_q;
   assign tx.DONE  = done_q;
   assign tx.BUSY  = busy_q;
   assign tx.FULL  = fifo_full;
   assign tx.EMPTY = fifo_empty;
   assign tx.OVF   = fifo_ovf;

endmodule

// File: tb/tb_fir_stream_tx.sv
// Directed bench for fir_stream_tx: reset, pacing, FIFO limits, STOP/restart, mid-stream reset.
// Inputs change 1 time unit after a rising edge; outputs are read at the same point.
module tb_fir_stream_tx;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests_run    = 0;
   int   tests_failed = 0;

   fir_stream_tx_if #(.DW(11), .GW(4)) bus ();

   fir_stream_tx #(.DW(11), .DEPTH(16), .GW(4)) dut (
      .CLK (clk),
      .RST (rst),
      .tx  (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [10:0] d);
      bus.WR_EN   = 1'b1;
      bus.WR_DATA = d;
      tick();
      bus.WR_EN   = 1'b0;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
      tests_run++; if (bus.DOUT !== 11'd0) begin tests_failed++; $display("FAIL reset_dout: got %0h expected 0", bus.DOUT); end
      tests_run++; if (bus.VOUT !== 1'b0) begin tests_failed++; $display("FAIL reset_vout: got %b expected 0", bus.VOUT); end
      tests_run++; if (bus.EMPTY !== 1'b1) begin tests_failed++; $display("FAIL reset_empty: got %b expected 1", bus.EMPTY); end
      tests_run++; if (bus.DONE !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", bus.DONE); end
      tests_run++; if (bus.BUSY !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", bus.BUSY); end
      tests_run++; if (bus.FULL !== 1'b0) begin tests_failed++; $display("FAIL reset_full: got %b expected 0", bus.FULL); end
      tests_run++; if (bus.OVF !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf: got %b expected 0", bus.OVF); end
   endtask

   task automatic test_empty_start();
      int bad = 0;
      bus.START = 1'b1;
      tick();
      bus.START = 1'b0;
      tests_run++; if (bus.BUSY !== 1'b0) begin tests_failed++; $display("FAIL empty_start_busy: got %b expected 0", bus.BUSY); end
      for (int c = 0; c < 5; c++) begin
         tick();
         if (bus.DONE !== 1'b0 || bus.VOUT !== 1'b0 || bus.BUSY !== 1'b0) bad++;
      end
      tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL empty_start_quiet: got %0d active cycles expected 0", bad); end
   endtask

   task automatic test_back_to_back();
      logic [10:0] exp_d [3];
      exp_d[0] = 11'd3;
      exp_d[1] = 11'h7FF;
      exp_d[2] = 11'd1023;
      for (int i = 0; i < 3; i++) push(exp_d[i]);
      bus.GAP   = 4'd0;
      bus.START = 1'b1;
      tick();
      bus.START = 1'b0;
      tests_run++; if (bus.BUSY !== 1'b1 || bus.VOUT !== 1'b0) begin tests_failed++; $display("FAIL b2b_start: got busy=%b vout=%b expected busy=1 vout=0", bus.BUSY, bus.VOUT); end
      for (int i = 0; i < 3; i++) begin
         tick();
         tests_run++;
         if (bus.VOUT !== 1'b1 || bus.DOUT !== exp_d[i] || bus.DONE !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_sample%0d: got vout=%b dout=%0h done=%b expected vout=1 dout=%0h done=0", i, bus.VOUT, bus.DOUT, bus.DONE, exp_d[i]);
         end
      end
      tick();
      tests_run++;
      if (bus.DONE !== 1'b1 || bus.VOUT !== 1'b0 || bus.BUSY !== 1'b0 || bus.EMPTY !== 1'b1 || bus.DOUT !== 11'd1023) begin
         tests_failed++;
         $display("FAIL b2b_done: got done=%b vout=%b busy=%b empty=%b dout=%0h expected 1 0 0 1 3ff", bus.DONE, bus.VOUT, bus.BUSY, bus.EMPTY, bus.DOUT);
      end
      tick();
      tests_run++; if (bus.DONE !== 1'b0) begin tests_failed++; $display("FAIL b2b_done_pulse: got %b expected 0", bus.DONE); end
   endtask

   task automatic test_gap();
      logic [10:0] exp_d [4];
      int pulse_c [4];
      int n = 0;
      int done_c = -1;
      int coincide = 0;
      exp_d[0] = 11'd10;
      exp_d[1] = 11'd20;
      exp_d[2] = 11'd30;
      exp_d[3] = 11'd40;
      for (int i = 0; i < 4; i++) push(exp_d[i]);
      bus.GAP   = 4'd2;
      bus.START = 1'b1;
      tick();
      bus.START = 1'b0;
      bus.GAP   = 4'd0;
      for (int c = 1; c <= 40 && done_c < 0; c++) begin
         tick();
         if (bus.VOUT === 1'b1) begin
            if (bus.DONE === 1'b1) coincide++;
            if (n < 4) begin
               pulse_c[n] = c;
               tests_run++;
               if (bus.DOUT !== exp_d[n]) begin tests_failed++; $display("FAIL gap_data%0d: got %0d expected %0d", n, bus.DOUT, exp_d[n]); end
            end
            n++;
         end
         if (bus.DONE === 1'b1) done_c = c;
      end
      tests_run++; if (n !== 4) begin tests_failed++; $display("FAIL gap_pulses: got %0d expected 4", n); end
      tests_run++; if (coincide !== 0) begin tests_failed++; $display("FAIL gap_done_vout: got %0d overlaps expected 0", coincide); end
      if (n == 4) begin
         for (int i = 1; i < 4; i++) begin
            tests_run++;
            if (pulse_c[i] - pulse_c[i-1] !== 3) begin tests_failed++; $display("FAIL gap_spacing%0d: got %0d expected 3", i, pulse_c[i] - pulse_c[i-1]); end
         end
         tests_run++; if (pulse_c[0] !== 1) begin tests_failed++; $display("FAIL gap_latency: got %0d expected 1", pulse_c[0]); end
         tests_run++; if (done_c - pulse_c[3] !== 3) begin tests_failed++; $display("FAIL gap_done_delay: got %0d expected 3", done_c - pulse_c[3]); end
      end
   endtask

   task automatic test_push_pop_full();
      int n = 1;
      int done_seen = 0;
      logic [10:0] e;
      pulse_reset();
      for (int i = 0; i < 16; i++) push(11'(i * 37 + 2));
      tests_run++; if (bus.FULL !== 1'b1 || bus.OVF !== 1'b0) begin tests_failed++; $display("FAIL ppf_filled: got full=%b ovf=%b expected 1 0", bus.FULL, bus.OVF); end
      bus.GAP   = 4'd0;
      bus.START = 1'b1;
      tick();
      bus.START   = 1'b0;
      bus.WR_EN   = 1'b1;
      bus.WR_DATA = 11'h2AA;
      tick();
      bus.WR_EN = 1'b0;
      tests_run++;
      if (bus.FULL !== 1'b1 || bus.OVF !== 1'b0 || bus.VOUT !== 1'b1 || bus.DOUT !== 11'd2) begin
         tests_failed++;
         $display("FAIL ppf_same_cycle: got full=%b ovf=%b vout=%b dout=%0d expected 1 0 1 2", bus.FULL, bus.OVF, bus.VOUT, bus.DOUT);
      end
      for (int c = 0; c < 40 && done_seen == 0; c++) begin
         tick();
         if (bus.VOUT === 1'b1) begin
            e = (n < 16) ? 11'(n * 37 + 2) : 11'h2AA;
            tests_run++;
            if (bus.DOUT !== e) begin tests_failed++; $display("FAIL ppf_data%0d: got %0h expected %0h", n, bus.DOUT, e); end
            n++;
         end
         if (bus.DONE === 1'b1) done_seen = 1;
      end
      tests_run++; if (n !== 17 || done_seen !== 1) begin tests_failed++; $display("FAIL ppf_count: got %0d samples done=%0d expected 17 done=1", n, done_seen); end
   endtask

   task automatic test_full_ovf();
      int n = 0;
      int done_seen = 0;
      for (int i = 0; i < 16; i++) begin
         push(11'h400 + 11'(i));
         if (i == 14) begin
            tests_run++; if (bus.FULL !== 1'b0) begin tests_failed++; $display("FAIL ovf_not_full15: got %b expected 0", bus.FULL); end
         end
      end
      tests_run++; if (bus.FULL !== 1'b1 || bus.OVF !== 1'b0) begin tests_failed++; $display("FAIL ovf_full16: got full=%b ovf=%b expected 1 0", bus.FULL, bus.OVF); end
      push(11'h123);
      tests_run++; if (bus.OVF !== 1'b1 || bus.FULL !== 1'b1) begin tests_failed++; $display("FAIL ovf_set: got ovf=%b full=%b expected 1 1", bus.OVF, bus.FULL); end
      tick();
      tick();
      tests_run++; if (bus.OVF !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky: got %b expected 1", bus.OVF); end
      bus.GAP   = 4'd0;
      bus.START = 1'b1;
      tick();
      bus.START = 1'b0;
      for (int c = 0; c < 40 && done_seen == 0; c++) begin
         tick();
         if (bus.VOUT === 1'b1) begin
            tests_run++;
            if (bus.DOUT !== 11'h400 + 11'(n)) begin tests_failed++; $display("FAIL ovf_data%0d: got %0h expected %0h", n, bus.DOUT, 11'h400 + 11'(n)); end
            n++;
         end
         if (bus.DONE === 1'b1) done_seen = 1;
      end
      tests_run++; if (n !== 16 || done_seen !== 1) begin tests_failed++; $display("FAIL ovf_stream_count: got %0d done=%0d expected 16 done=1", n, done_seen); end
      tests_run++; if (bus.OVF !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky_after: got %b expected 1", bus.OVF); end
   endtask

   task automatic test_reset_midstream();
      int bad = 0;
      tests_run++; if (bus.OVF !== 1'b1) begin tests_failed++; $display("FAIL rmid_pre_ovf: got %b expected 1", bus.OVF); end
      push(11'd5);
      push(11'd6);
      push(11'd7);
      bus.GAP   = 4'd3;
      bus.START = 1'b1;
      tick();
      bus.START = 1'b0;
      tick();
      tests_run++; if (bus.VOUT !== 1'b1 || bus.DOUT !== 11'd5) begin tests_failed++; $display("FAIL rmid_first: got vout=%b dout=%0d expected 1 5", bus.VOUT, bus.DOUT); end
      tick();
      tests_run++; if (bus.VOUT !== 1'b0 || bus.BUSY !== 1'b1) begin tests_failed++; $display("FAIL rmid_wait: got vout=%b busy=%b expected 0 1", bus.VOUT, bus.BUSY); end
      pulse_reset();
      tests_run++;
      if (bus.DOUT !== 11'd0 || bus.VOUT !== 1'b0 || bus.DONE !== 1'b0 || bus.BUSY !== 1'b0 ||
          bus.EMPTY !== 1'b1 || bus.FULL !== 1'b0 || bus.OVF !== 1'b0) begin
         tests_failed++;
         $display("FAIL rmid_reset: got dout=%0d vout=%b done=%b busy=%b empty=%b full=%b ovf=%b expected 0 0 0 0 1 0 0",
                  bus.DOUT, bus.VOUT, bus.DONE, bus.BUSY, bus.EMPTY, bus.FULL, bus.OVF);
      end
      bus.START = 1'b1;
      tick();
      bus.START = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (bus.VOUT !== 1'b0 || bus.DONE !== 1'b0 || bus.BUSY !== 1'b0) bad++;
         tick();
      end
      tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL rmid_start_ignored: got %0d active cycles expected 0", bad); end
   endtask

   task automatic test_stop_restart();
      int n = 0;
      int bad = 0;
      int done_seen = 0;
      pulse_reset();
      for (int i = 0; i < 8; i++) push(11'h7F8 + 11'(i));
      bus.GAP   = 4'd1;
      bus.START = 1'b1;
      tick();
      bus.START = 1'b0;
      for (int c = 0; c < 20 && n < 3; c++) begin
         tick();
         if (bus.VOUT === 1'b1) begin
            tests_run++;
            if (bus.DOUT !== 11'h7F8 + 11'(n)) begin tests_failed++; $display("FAIL stop_data%0d: got %0h expected %0h", n, bus.DOUT, 11'h7F8 + 11'(n)); end
            n++;
         end
      end
      tests_run++; if (n !== 3) begin tests_failed++; $display("FAIL stop_pre_pulses: got %0d expected 3", n); end
      bus.STOP = 1'b1;
      tick();
      bus.STOP = 1'b0;
      tests_run++; if (bus.BUSY !== 1'b0 || bus.VOUT !== 1'b0) begin tests_failed++; $display("FAIL stop_idle: got busy=%b vout=%b expected 0 0", bus.BUSY, bus.VOUT); end
      for (int c = 0; c < 8; c++) begin
         tick();
         if (bus.VOUT !== 1'b0 || bus.DONE !== 1'b0) bad++;
      end
      tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL stop_quiet: got %0d active cycles expected 0", bad); end
      tests_run++; if (bus.EMPTY !== 1'b0) begin tests_failed++; $display("FAIL stop_empty: got %b expected 0", bus.EMPTY); end
      bus.START = 1'b1;
      tick();
      bus.START = 1'b0;
      for (int c = 0; c < 40 && done_seen == 0; c++) begin
         tick();
         if (bus.VOUT === 1'b1) begin
            tests_run++;
            if (bus.DOUT !== 11'h7F8 + 11'(n)) begin tests_failed++; $display("FAIL restart_data%0d: got %0h expected %0h", n, bus.DOUT, 11'h7F8 + 11'(n)); end
            n++;
         end
         if (bus.DONE === 1'b1) done_seen = 1;
      end
      tests_run++; if (n !== 8 || done_seen !== 1) begin tests_failed++; $display("FAIL restart_count: got %0d total done=%0d expected 8 done=1", n, done_seen); end
   endtask

   initial begin
      bus.WR_EN   = 1'b0;
      bus.WR_DATA = '0;
      bus.START   = 1'b0;
      bus.STOP    = 1'b0;
      bus.GAP     = '0;
      test_reset();
      test_empty_start();
      test_back_to_back();
      test_gap();
      test_push_pop_full();
      test_full_ovf();
      test_reset_midstream();
      test_stop_restart();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/fir_stream_tx.md
# fir_stream_tx

Synthesizable sample transmitter that drives the FIR input stream (the data/valid pair consumed on the filter's DIN/VIN side). Samples are preloaded into an internal FIFO through a simple write port. After a START pulse they are emitted one per valid pulse, with a programmable number of idle cycles between samples. The block replaces the behavioural data source on FPGA/post-synthesis benches and marks completion with DONE.

## Interface
- DW, 11: sample width, matching the FIR data width.
- DEPTH, 16: FIFO depth in samples (power of two, ≥2).
- GW, 4: width of the gap-length field.
- CLK  in  1  single clock; all logic rising-edge.
- RST  in  1  synchronous, active-high reset.
- WR_EN  in  1  push WR_DATA into the FIFO this cycle.
- WR_DATA  in  DW  sample to push (two's complement).
- START  in  1  one-cycle pulse; begin streaming (honoured only in IDLE).
- STOP  in  1  abort streaming; return to IDLE, FIFO content kept.
- GAP  in  GW  idle cycles between consecutive valid samples; latched at START.
- DOUT  out  DW  sample to FIR DIN; holds the last emitted value between pulses.
- VOUT  out  1  sample valid to FIR VIN; one-cycle pulse per sample.
- FULL  out  1  FIFO holds DEPTH samples.
- EMPTY  out  1  FIFO holds 0 samples.
- BUSY  out  1  state is SEND or WAIT.
- DONE  out  1  one-cycle pulse when the FIFO has drained during streaming.
- OVF  out  1  sticky: write attempted while FULL; cleared only by RST.

## Operation
- Reset values: DOUT=0, VOUT=0, DONE=0, OVF=0, BUSY=0, EMPTY=1, FULL=0, FIFO pointers=0, state=IDLE, gap register=0.
- FIFO: a write while FULL is dropped and sets OVF. A simultaneous push and pop is allowed in every state, including FULL (count unchanged, both executed) and EMPTY with no pop (push only). Pointers wrap modulo DEPTH; a count of log2(DEPTH)+1 bits distinguishes full from empty.
- FSM states: IDLE, SEND, WAIT.
- IDLE: on START with EMPTY=0, latch GAP into gap_len and go to SEND. START while EMPTY=1 is ignored (no DONE). WR_EN is accepted in all states.
- SEND, count>0:
  - pop head; DOUT<=head; VOUT<=1.
  - If gap_len=0, stay in SEND.
  - Otherwise load gap_cnt=gap_len and go to WAIT.
- SEND, count=0: DONE<=1 and go to IDLE. Samples pushed in that same cycle stay queued for the next START.
- WAIT: decrement gap_cnt each cycle; when gap_cnt=1, go to SEND. VOUT=0 throughout.
- STOP (SEND or WAIT): go to IDLE on that edge. No pop, no VOUT, no DONE. STOP has priority over all SEND actions. STOP in IDLE has no effect.
- START received in SEND/WAIT is ignored. GAP changes after START have no effect until the next START.
- Data is passed through unmodified (no sign handling); full DW bits are stored.

## Timing
- All outputs are registered.
- START sampled at edge k: state=SEND after k. The first VOUT is high in the cycle after edge k+1. Start-to-first-valid latency is 2 edges.
- Consecutive VOUT pulses are spaced GAP+1 cycles apart.
- DONE fires one edge after the last valid pulse when GAP=0, or GAP+1 edges after it otherwise. DONE is never coincident with VOUT.
- FULL, EMPTY and OVF reflect FIFO state after the edge, so a write in cycle k is visible in EMPTY after edge k.
- RST mid-stream: all state returns to reset values on that edge and the queued samples are lost.

## Structure
- Package fir_tx_pkg holds the DW default, the state enum tx_state_t {IDLE, SEND, WAIT}, and the log2 helper constant for pointer width.
- Sub-module fir_tx_fifo (parameterised DW/DEPTH synchronous FIFO with FULL/EMPTY/count). The pacing FSM, gap counter and output registers live in the top module.

## Test plan
- Reset/idle:
  - Stimulus: assert RST for 2 cycles, then idle.
  - Required: DOUT=0, VOUT=0, EMPTY=1, DONE=0.
  - Stimulus: START with an empty FIFO.
  - Required: stays IDLE, no DONE.
- Back-to-back:
  - Stimulus: push 3, -1 (0x7FF), 1023; GAP=0; START at edge k.
  - Required: VOUT high after edges k+1..k+3 with DOUT 3, 0x7FF, 1023 in order. DONE after k+4. BUSY low after k+4.
- Gap pacing:
  - Stimulus: push 4 samples; GAP=2; START.
  - Required: VOUT pulses exactly 3 cycles apart, 4 pulses. DONE 3 edges after the last pulse.
- Full/overflow:
  - Stimulus: push 17 samples with DEPTH=16.
  - Required: FULL after the 16th push; 17th dropped; OVF=1 and sticky. Streaming emits exactly 16 samples in order.
  - Stimulus: push+pop in the same cycle while FULL.
  - Required: FULL stays 1, no OVF.
- STOP/restart:
  - Stimulus: 8 samples, GAP=1; STOP after the 3rd pulse.
  - Required: no further VOUT, no DONE, EMPTY=0.
  - Stimulus: a second START.
  - Required: samples 4..8 emitted, then DONE.
- Reset mid-stream:
  - Stimulus: RST during WAIT.
  - Required: next cycle all outputs at reset values, EMPTY=1, OVF=0; a subsequent START is ignored.
